// File: rtl/fp_minmax_pipe_if.sv
// rtl/fp_minmax_pipe_if.sv - operand/result handshake bundle for fp_minmax_pipe
interface fp_minmax_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [W-1:0]     input_a;
  logic [W-1:0]     input_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     output_z;
  logic [TAG_W-1:0] out_tag;
  logic             flag_nv;

  modport master (
    output in_valid, op, input_a, input_b, in_tag, out_ready,
    input  in_ready, out_valid, output_z, out_tag, flag_nv
  );

  modport slave (
    input  in_valid, op, input_a, input_b, in_tag, out_ready,
    output in_ready, out_valid, output_z, out_tag, flag_nv
  );
endinterface

// File: rtl/fp_minmax_pipe.sv
// rtl/fp_minmax_pipe.sv - pipelined IEEE-754 min/max unit (FP_MINMAX_CMP_EN adds FEQ/FLT/FLE)
module fp_minmax_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int PIPE  = 2,
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  fp_minmax_pipe_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
  } cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t c;
    c.nan  = (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    c.snan = c.nan && !x[MAN_W-1];
    c.zero = ~|x[W-2:0];
    return c;
  endfunction

  // Sign-magnitude ordering; -0 sorts below +0 so MIN/MAX pick the right zero.
  function automatic logic lt_ord(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    if (a[W-1] != b[W-1]) r = a[W-1];
    else if (a[W-1])      r = a[W-2:0] > b[W-2:0];
    else                  r = a[W-2:0] < b[W-2:0];
    return r;
  endfunction

  // Operands as seen by the final (select) stage
  logic             f_valid;
  logic [W-1:0]     f_a, f_b;
  cls_t             f_ca, f_cb;
  logic [2:0]       f_op;
  logic [TAG_W-1:0] f_tag;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     z_q;
  logic [TAG_W-1:0] tag_q;
  logic             nv_q;
  logic             adv_last;

  assign adv_last = !out_valid_q || io.out_ready;

  if (PIPE == 2) begin : g_two
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_b_q;
    cls_t             s1_ca_q, s1_cb_q;
    logic [2:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_adv;

    assign s1_adv      = !s1_valid_q || adv_last;
    assign io.in_ready = s1_adv;

    // Stage-1 occupancy: flush wins, otherwise refill whenever the stage moves
    always_comb begin
      s1_valid_d = s1_valid_q;
      if (flush)       s1_valid_d = 1'b0;
      else if (s1_adv) s1_valid_d = io.in_valid;
    end

    // Stage 1: capture operands with their NaN/zero classification
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
        s1_ca_q    <= '0;
        s1_cb_q    <= '0;
        s1_op_q    <= '0;
        s1_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        if (s1_adv && io.in_valid) begin
          s1_a_q   <= io.input_a;
          s1_b_q   <= io.input_b;
          s1_ca_q  <= classify(io.input_a);
          s1_cb_q  <= classify(io.input_b);
          s1_op_q  <= io.op;
          s1_tag_q <= io.in_tag;
        end
      end
    end

    assign f_valid = s1_valid_q;
    assign f_a     = s1_a_q;
    assign f_b     = s1_b_q;
    assign f_ca    = s1_ca_q;
    assign f_cb    = s1_cb_q;
    assign f_op    = s1_op_q;
    assign f_tag   = s1_tag_q;
  end else begin : g_one
    assign io.in_ready = adv_last;
    assign f_valid     = io.in_valid;
    assign f_a         = io.input_a;
    assign f_b         = io.input_b;
    assign f_ca        = classify(io.input_a);
    assign f_cb        = classify(io.input_b);
    assign f_op        = io.op;
    assign f_tag       = io.in_tag;
  end

  logic [W-1:0] res_z;
  logic         res_nv;

`ifdef FP_MINMAX_CMP_EN
  logic any_nan, both_zero, eq_ieee, lt_ieee;
  assign any_nan   = f_ca.nan || f_cb.nan;
  assign both_zero = f_ca.zero && f_cb.zero;
  assign eq_ieee   = (f_a == f_b) || both_zero;
  assign lt_ieee   = lt_ord(f_a, f_b) && !both_zero;
`else
  logic unused_cmp;
  assign unused_cmp = ^{f_op[2:1], f_ca.zero, f_cb.zero};
`endif

  // Select/compare result for the operation in the final stage
  always_comb begin
    res_nv = f_ca.snan || f_cb.snan;
    if (f_ca.nan && f_cb.nan) res_z = CANON_NAN;
    else if (f_ca.nan)        res_z = f_b;
    else if (f_cb.nan)        res_z = f_a;
    else if (f_op[0])         res_z = lt_ord(f_a, f_b) ? f_b : f_a;
    else                      res_z = lt_ord(f_b, f_a) ? f_b : f_a;
`ifdef FP_MINMAX_CMP_EN
    case (f_op)
      3'b010: res_z = {{(W-1){1'b0}}, !any_nan && eq_ieee};
      3'b011: begin
        res_z  = {{(W-1){1'b0}}, !any_nan && lt_ieee};
        res_nv = any_nan;
      end
      3'b100: begin
        res_z  = {{(W-1){1'b0}}, !any_nan && (lt_ieee || eq_ieee)};
        res_nv = any_nan;
      end
      default: ;
    endcase
`endif
  end

  // Output occupancy: flush clears it regardless of out_ready
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)         out_valid_d = 1'b0;
    else if (adv_last) out_valid_d = f_valid;
  end

  // Output register: holds while stalled, reloads only with a live op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      z_q         <= '0;
      tag_q       <= '0;
      nv_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (adv_last && f_valid) begin
        z_q   <= res_z;
        tag_q <= f_tag;
        nv_q  <= res_nv;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.output_z  = z_q;
  assign io.out_tag   = tag_q;
  assign io.flag_nv   = nv_q;
endmodule

// File: tb/tb_fp_minmax_pipe.sv
// tb/tb_fp_minmax_pipe.sv - directed-vector bench for fp_minmax_pipe
module tb_fp_minmax_pipe;
  localparam int PIPE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  fp_minmax_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) bus ();

  fp_minmax_pipe #(.EXP_W(8), .MAN_W(23), .PIPE(PIPE), .TAG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with an empty pipe; leaves at posedge+1 with the pipe drained.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_z, input logic exp_nv);
    int lat;
    bus.op = op; bus.input_a = a; bus.input_b = b; bus.in_tag = tag;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, PIPE);
    check({name, "_z"}, bus.output_z, exp_z);
    check({name, "_tag"}, {27'd0, bus.out_tag}, {27'd0, tag});
    check({name, "_nv"}, {31'd0, bus.flag_nv}, {31'd0, exp_nv});
    @(posedge clk); #1;
  endtask

  logic [2:0]  s_op [8];
  logic [31:0] s_a  [8];
  logic [31:0] s_b  [8];
  logic [31:0] s_z  [8];

  initial begin
    int  sent, got;
    bit  saw_bp, in_xfer, leaked;

    s_op[0] = 3'b000; s_a[0] = 32'h3F800000; s_b[0] = 32'h40000000; s_z[0] = 32'h3F800000;
    s_op[1] = 3'b001; s_a[1] = 32'h3F800000; s_b[1] = 32'h40000000; s_z[1] = 32'h40000000;
    s_op[2] = 3'b000; s_a[2] = 32'hBF800000; s_b[2] = 32'h3F800000; s_z[2] = 32'hBF800000;
    s_op[3] = 3'b001; s_a[3] = 32'hBF800000; s_b[3] = 32'h3F800000; s_z[3] = 32'h3F800000;
    s_op[4] = 3'b000; s_a[4] = 32'hC0400000; s_b[4] = 32'hC0000000; s_z[4] = 32'hC0400000;
    s_op[5] = 3'b001; s_a[5] = 32'hC0400000; s_b[5] = 32'hC0000000; s_z[5] = 32'hC0000000;
    s_op[6] = 3'b000; s_a[6] = 32'h7FC00000; s_b[6] = 32'h00800000; s_z[6] = 32'h00800000;
    s_op[7] = 3'b001; s_a[7] = 32'h00000001; s_b[7] = 32'h80000001; s_z[7] = 32'h00000001;

    bus.in_valid = 1'b0; bus.op = '0; bus.input_a = '0; bus.input_b = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_output_z", bus.output_z, 32'd0);
    check("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
    check("rst_flag_nv", {31'd0, bus.flag_nv}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op("min_1_m2",   3'b000, 32'h3F800000, 32'hC0000000, 5'd3,  32'hC0000000, 1'b0);
    run_op("max_1_m2",   3'b001, 32'h3F800000, 32'hC0000000, 5'd4,  32'h3F800000, 1'b0);
    run_op("min_p0_m0",  3'b000, 32'h00000000, 32'h80000000, 5'd5,  32'h80000000, 1'b0);
    run_op("max_p0_m0",  3'b001, 32'h00000000, 32'h80000000, 5'd6,  32'h00000000, 1'b0);
    run_op("max_qnan",   3'b001, 32'h7FC00000, 32'h40400000, 5'd7,  32'h40400000, 1'b0);
    run_op("min_2nan",   3'b000, 32'h7F800001, 32'h7FC00000, 5'd8,  32'h7FC00000, 1'b1);
    run_op("min_neg",    3'b000, 32'hBF800000, 32'hC0000000, 5'd9,  32'hC0000000, 1'b0);
    run_op("min_subn",   3'b000, 32'h00000002, 32'h00000001, 5'd10, 32'h00000001, 1'b0);
    run_op("op110_min",  3'b110, 32'h40400000, 32'h3F800000, 5'd11, 32'h3F800000, 1'b0);
    run_op("op111_max",  3'b111, 32'h40400000, 32'h3F800000, 5'd12, 32'h40400000, 1'b0);
    run_op("max_snan1",  3'b001, 32'h3F800000, 32'hFF800001, 5'd13, 32'h3F800000, 1'b1);
`ifdef FP_MINMAX_CMP_EN
    run_op("flt_m1_1",   3'b011, 32'hBF800000, 32'h3F800000, 5'd14, 32'h00000001, 1'b0);
    run_op("feq_zeros",  3'b010, 32'h80000000, 32'h00000000, 5'd15, 32'h00000001, 1'b0);
    run_op("fle_qnan",   3'b100, 32'h7FC00000, 32'h3F800000, 5'd16, 32'h00000000, 1'b1);
    run_op("flt_zeros",  3'b011, 32'h80000000, 32'h00000000, 5'd17, 32'h00000000, 1'b0);
`else
    run_op("op010_min",  3'b010, 32'h3F800000, 32'hBF800000, 5'd14, 32'hBF800000, 1'b0);
`endif

    // Back-to-back stream with a three-cycle downstream stall
    sent = 0; got = 0; saw_bp = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) begin
        bus.in_valid = 1'b1; bus.op = s_op[sent];
        bus.input_a = s_a[sent]; bus.input_b = s_b[sent]; bus.in_tag = 5'(sent + 16);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && !bus.in_ready) saw_bp = 1'b1;
      if (bus.out_valid && !bus.out_ready && got < 8)
        check("stall_hold_z", bus.output_z, s_z[got]);
      if (bus.out_valid && bus.out_ready) begin
        if (got < 8) begin
          check("stream_z", bus.output_z, s_z[got]);
          check("stream_tag", {27'd0, bus.out_tag}, 32'(got + 16));
        end else begin
          check("stream_extra", {31'd0, bus.out_valid}, 32'd0);
        end
        got++;
      end
      in_xfer = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (in_xfer) sent++;
    end
    check("stream_count", got, 32'd8);
    check("stream_backpressure", {31'd0, saw_bp}, 32'd1);

    // Flush with two ops in flight and a third presented in the flush cycle
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.op = 3'b001;
      bus.input_a = 32'h41000000 + k; bus.input_b = 32'h3F800000; bus.in_tag = 5'(k + 1);
      if (k == 2) begin
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    leaked = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) leaked = 1'b1;
    end
    check("flush_no_leak", {31'd0, leaked}, 32'd0);

    // Asynchronous reset while a result is stalled at the output
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 3'b000;
    bus.input_a = 32'h7F800001; bus.input_b = 32'h3F800000; bus.in_tag = 5'd30;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_async_z", bus.output_z, 32'd0);
    check("rst_async_nv", {31'd0, bus.flag_nv}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 3'b001, 32'h40400000, 32'hC0400000, 5'd31, 32'h40400000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
